// File: rtl/branch_resolve_unit.sv
// Branch resolution + 2-bit saturating PHT for the MIPS pipeline.
// Define BRU_STATS_EN to build the saturating statistics counters.
module branch_resolve_unit #(
    parameter int WIDTH     = 32,
    parameter int PHT_DEPTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pred_pc,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic [31:0]      res_pc,
    input  logic [2:0]       res_op,
    input  logic [WIDTH-1:0] res_a,
    input  logic [WIDTH-1:0] res_b,
    input  logic             res_pred_taken,
    output logic             res_taken,
    output logic             mispredict,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispred
);
    localparam int IDX = $clog2(PHT_DEPTH);

    logic [1:0]           pht [PHT_DEPTH];
    logic [IDX-1:0]       pidx;
    logic [IDX-1:0]       ridx;
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic                 cond;
    logic [1:0]           cur;
    logic                 unused_bits;

    assign pidx = pred_pc[IDX+1:2];
    assign ridx = res_pc[IDX+1:2];
    assign sa   = res_a;
    assign sb   = res_b;
    assign cur  = pht[ridx];

    // Fetch reads the stored counter; an update this cycle is not bypassed.
    assign pred_taken = pht[pidx][1];

    assign unused_bits = ^{pred_pc[31:IDX+2], pred_pc[1:0],
                           res_pc[31:IDX+2], res_pc[1:0]};

    always_comb begin
        cond = 1'b0;
        unique case (res_op)
            3'd0: cond = (sa == sb);
            3'd1: cond = (sa != sb);
            3'd2: cond = (sa <= 0);
            3'd3: cond = (sa > 0);
            3'd4: cond = (sa < 0);
            3'd5: cond = (sa >= 0);
            3'd6: cond = (sa < sb);
            3'd7: cond = (sa >= sb);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht[i] <= 2'b01;
            end
            res_taken  <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            mispredict <= 1'b0;
            if (res_valid) begin
                res_taken  <= cond;
                mispredict <= cond ^ res_pred_taken;
                if (cond && cur != 2'b11) begin
                    pht[ridx] <= cur + 2'd1;
                end else if (!cond && cur != 2'b00) begin
                    pht[ridx] <= cur - 2'd1;
                end
            end
        end
    end

`ifdef BRU_STATS_EN
    logic [31:0] nbr;
    logic [31:0] nmis;

    always_ff @(posedge clk) begin
        if (reset) begin
            nbr  <= '0;
            nmis <= '0;
        end else if (res_valid) begin
            if (nbr != 32'hFFFF_FFFF) begin
                nbr <= nbr + 32'd1;
            end
            if ((cond ^ res_pred_taken) && nmis != 32'hFFFF_FFFF) begin
                nmis <= nmis + 32'd1;
            end
        end
    end

    assign stat_branches = nbr;
    assign stat_mispred  = nmis;
`else
    assign stat_branches = 32'd0;
    assign stat_mispred  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomised scoreboard bench for branch_resolve_unit.
// Reference model works on integer counters and signed arithmetic.
module tb_branch_resolve_unit;
    localparam int WIDTH = 32;
    localparam int DEPTH = 64;

    typedef struct {
        logic        rt;
        logic        mis;
        logic [31:0] nb;
        logic [31:0] nm;
        string       tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      pred_pc;
    logic             pred_taken;
    logic             res_valid;
    logic [31:0]      res_pc;
    logic [2:0]       res_op;
    logic [WIDTH-1:0] res_a;
    logic [WIDTH-1:0] res_b;
    logic             res_pred_taken;
    logic             res_taken;
    logic             mispredict;
    logic [31:0]      stat_branches;
    logic [31:0]      stat_mispred;

    int checks = 0;
    int errors = 0;

    exp_t sbq[$];

    int          cnt [DEPTH];
    logic        m_rt;
    longint      m_nb;
    longint      m_nm;
    bit          known = 0;
    bit          done = 0;

    branch_resolve_unit #(.WIDTH(WIDTH), .PHT_DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .pred_pc(pred_pc),
        .pred_taken(pred_taken),
        .res_valid(res_valid),
        .res_pc(res_pc),
        .res_op(res_op),
        .res_a(res_a),
        .res_b(res_b),
        .res_pred_taken(res_pred_taken),
        .res_taken(res_taken),
        .mispredict(mispredict),
        .stat_branches(stat_branches),
        .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    function automatic int idx(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic bit eval(input logic [2:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b);
        longint x = longint'($signed(a));
        longint y = longint'($signed(b));
        case (op)
            3'd0: return x == y;
            3'd1: return x != y;
            3'd2: return x <= 0;
            3'd3: return x > 0;
            3'd4: return x < 0;
            3'd5: return x >= 0;
            3'd6: return x < y;
            default: return x >= y;
        endcase
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock cycle: drive, check prediction, update model, queue expectation.
    task automatic step(input bit rst, input bit v, input logic [31:0] pc,
                        input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit pt,
                        input logic [31:0] ppc, input string tag);
        exp_t e;
        bit c;
        @(negedge clk);
        reset = rst;
        res_valid = v;
        res_pc = pc;
        res_op = op;
        res_a = a;
        res_b = b;
        res_pred_taken = pt;
        pred_pc = ppc;
        #1;
        if (known) chk({tag, "/pred"}, pred_taken, cnt[idx(ppc)] >= 2);
        e.mis = 1'b0;
        if (rst) begin
            foreach (cnt[i]) cnt[i] = 1;
            m_rt = 1'b0;
            m_nb = 0;
            m_nm = 0;
            known = 1;
        end else if (v) begin
            c = eval(op, a, b);
            m_rt = c;
            e.mis = c ^ pt;
            if (c) cnt[idx(pc)] = (cnt[idx(pc)] == 3) ? 3 : cnt[idx(pc)] + 1;
            else   cnt[idx(pc)] = (cnt[idx(pc)] == 0) ? 0 : cnt[idx(pc)] - 1;
            if (m_nb < 64'hFFFF_FFFF) m_nb++;
            if (e.mis && m_nm < 64'hFFFF_FFFF) m_nm++;
        end
        e.rt = m_rt;
`ifdef BRU_STATS_EN
        e.nb = m_nb[31:0];
        e.nm = m_nm[31:0];
`else
        e.nb = 32'd0;
        e.nm = 32'd0;
`endif
        e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic idle(input logic [31:0] ppc, input string tag);
        step(0, 0, 32'h0, 3'd0, 32'h0, 32'h0, 0, ppc, tag);
    endtask

    // Monitor: after every edge the DUT presents one cycle's outcome.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk({e.tag, "/res_taken"}, res_taken, e.rt);
                chk({e.tag, "/mispredict"}, mispredict, e.mis);
                chk({e.tag, "/stat_branches"}, stat_branches, e.nb);
                chk({e.tag, "/stat_mispred"}, stat_mispred, e.nm);
            end
        end
    end

    initial begin
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        int          wait_cyc;

        reset = 1'b1;
        res_valid = 1'b0;
        res_pc = '0;
        res_op = '0;
        res_a = '0;
        res_b = '0;
        res_pred_taken = 1'b0;
        pred_pc = 32'h3000;

        step(1, 0, 0, 0, 0, 0, 0, 32'h3000, "reset0");
        step(1, 0, 0, 0, 0, 0, 0, 32'h3000, "reset1");
        idle(32'h3000, "post_reset");

        step(0, 1, 32'h3000, 3'd0, 5, 5, 0, 32'h3000, "beq1");
        step(0, 1, 32'h3000, 3'd0, 5, 5, 0, 32'h3000, "beq2");
        idle(32'h3000, "beq_pred");

        step(0, 1, 32'h3100, 3'd6, 32'hFFFF_FFFF, 1, 1, 32'h3000, "blt_neg");
        step(0, 1, 32'h3100, 3'd3, 32'h8000_0000, 0, 1, 32'h3000, "bgtz_min");
        step(0, 1, 32'h3100, 3'd2, 32'h0, 32'h1234, 1, 32'h3000, "blez_zero");

        for (int i = 0; i < 5; i++)
            step(0, 1, 32'h3010, 3'd1, 7, 7, 0, 32'h3010, "sat_low");
        step(0, 1, 32'h3010, 3'd1, 7, 8, 0, 32'h3010, "sat_up");
        idle(32'h3010 + 4 * DEPTH, "alias");

        step(0, 1, 32'h3004, 3'd5, 0, 0, 0, 32'h3004, "collide");
        idle(32'h3004, "collide_next");

        step(0, 1, 32'h3000, 3'd0, 1, 1, 0, 32'h3000, "pre_rst");
        step(1, 1, 32'h3000, 3'd0, 1, 1, 0, 32'h3000, "rst_valid");
        idle(32'h3000, "after_rst");

        for (int i = 0; i < 10; i++)
            step(0, 1, 32'h3200, 3'd1, i, 0, 0, 32'h3000, "ten");

        for (int i = 0; i < 2000; i++) begin
            pc = 32'h3000 + 4 * $urandom_range(0, 7)
                 + 4 * DEPTH * $urandom_range(0, 3) + $urandom_range(0, 3);
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = a; end
                1: begin a = 32'h8000_0000; b = 32'h7FFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 2)) - 1; b = 0; end
                default: begin a = $urandom; b = $urandom; end
            endcase
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                 pc, op, a, b, $urandom_range(0, 1),
                 32'h3000 + 4 * $urandom_range(0, 7), "rand");
        end

        wait_cyc = 0;
        while (sbq.size() != 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("drain", sbq.size(), 0);
        done = 1;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution unit for the pipelined MIPS core: evaluates the branch condition of the instruction in the resolve stage and trains a direct-mapped table of 2-bit saturating counters. The fetch stage reads a taken/not-taken prediction from the same table. Resolution is registered, and a one-cycle mispredict pulse drives the hazard/flush logic. Optional statistics counters track resolved branches and mispredicts.

## Interface
- `WIDTH`, 32: operand width for `res_a`/`res_b`.
- `PHT_DEPTH`, 64: number of counters; power of two, at least 2; `IDX = log2(PHT_DEPTH)`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `pred_pc` in 32: fetch-stage PC to predict.
- `pred_taken` out 1: combinational, MSB of counter `pred_pc[IDX+1:2]`.
- `res_valid` in 1: a branch is present in the resolve stage this cycle.
- `res_pc` in 32: PC of the resolving branch.
- `res_op` in 3: condition code.
- `res_a`, `res_b` in WIDTH: operands, two's complement.
- `res_pred_taken` in 1: prediction carried down the pipe with this branch.
- `res_taken` out 1: registered actual outcome.
- `mispredict` out 1: registered one-cycle pulse.
- `stat_branches` out 32: resolved-branch count.
- `stat_mispred` out 32: mispredict count.

## Operation
- `res_op` encodings (all signed):
  - 0 beq: A==B
  - 1 bne: A!=B
  - 2 blez: A<=0
  - 3 bgtz: A>0
  - 4 bltz: A<0
  - 5 bgez: A>=0
  - 6 blt: A<B
  - 7 bge: A>=B
- `res_b` is ignored for ops 2–5.
- All 8 codes are legal branches. There is no reserved code.
- Counter index is `pc[IDX+1:2]`; `pc[1:0]` and the upper bits are ignored, so aliasing is permitted.
- Counter update on a cycle with `res_valid=1`, at the edge:
  - cond=1: counter increments, saturating at 3.
  - cond=0: counter decrements, saturating at 0.
- Prediction: `pred_taken = counter[1]` (2,3 means taken).
- When `res_valid=1`, at the edge:
  - `res_taken` <= cond.
  - `mispredict` <= cond XOR `res_pred_taken`.
- When `res_valid=0`:
  - `mispredict` <= 0.
  - `res_taken` holds its value.
- Stats:
  - `stat_branches` increments on each valid resolve.
  - `stat_mispred` increments on each mispredict.
  - Both saturate at 0xFFFFFFFF.

## Timing
- Reset values:
  - all counters 2'b01 (weakly not-taken).
  - `res_taken`=0, `mispredict`=0.
  - stats=0.
  - `pred_taken`=0 from the cycle after reset.
- Reset has priority over a simultaneous `res_valid`: no update occurs and no pulse is produced.
- Resolve latency is 1 cycle: inputs at edge N give outputs valid after edge N and visible during cycle N+1.
- Back-to-back `res_valid` every cycle is supported. The second update to the same index sees the first update's result, giving one increment per cycle.
- Read/write collision: a lookup in the same cycle as an update to the same index returns the pre-update value. The new value is visible the next cycle; there is no bypass.
- `mispredict` is never high for more than one cycle per resolved branch.

## Configuration
- `BRU_STATS_EN`:
  - Defined: both 32-bit saturating statistics counters are built.
  - Undefined: no counter flops are built, and `stat_branches`/`stat_mispred` are tied to 0.
  - The prediction and resolution behaviour is identical in both cases.

## Test plan
- Reset, then `pred_pc`=0x3000 → `pred_taken`=0. All outputs and stats are 0.
- Resolve op 0 with A=B=5, `res_pred_taken`=0, pc 0x3000, twice in consecutive cycles:
  - `res_taken`=1 and `mispredict`=1 on each.
  - Counter goes 01→10→11, so `pred_taken`=1 from the cycle after the first update.
- Signed checks, each resolved with `res_pred_taken`=1:
  - op 6, A=0xFFFFFFFF, B=1 → `res_taken`=1.
  - op 3, A=0x80000000 → `res_taken`=0, `mispredict`=1.
  - op 2, A=0 → `res_taken`=1.
- Saturation:
  - Five not-taken resolves at pc 0x3010 → counter stays 00.
  - One taken → 01, `pred_taken` still 0.
  - Aliasing: pc 0x3010+4·PHT_DEPTH reads the same counter.
- Collision: `pred_pc`=`res_pc`=0x3004 with counter 01 and a taken resolve → `pred_taken`=0 that cycle and 1 the next.
- Assert `reset` together with `res_valid` mid-stream → no pulse, stats=0, counters=01. With `BRU_STATS_EN` undefined, stats read 0 after 10 branches.
